// File: rtl/sd_mq_pkg.sv
// Shared types and helpers for the multi-queue memory arbiter.
//   rr_select     : round-robin priority select (request vector, pointer -> one-hot)
//   onehot_to_idx : one-hot vector -> binary index
//   bound_low_of / bound_high_of : static per-queue partition bounds
// Vectors are sized for the largest supported queue count; callers zero-extend.
package sd_mq_pkg;

    localparam int unsigned MAX_NQ = 16;
    localparam int unsigned IDX_W  = 4;

    // First set bit of req, searching upward from ptr and wrapping at n-1 -> 0.
    function automatic logic [MAX_NQ-1:0] rr_select(input logic [MAX_NQ-1:0] req,
                                                     input logic [IDX_W-1:0]  ptr,
                                                     input int unsigned        n);
        logic [MAX_NQ-1:0] grant;
        logic [IDX_W-1:0]  idx;
        logic              found;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NQ; k++) begin
            if (k < n) begin
                idx = IDX_W'((32'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < MAX_NQ; k++) begin
            if (vec[k]) idx = idx | IDX_W'(k);
        end
        return idx;
    endfunction

    function automatic int unsigned bound_low_of(input int unsigned i, input int unsigned qsz);
        return i * qsz;
    endfunction

    function automatic int unsigned bound_high_of(input int unsigned i, input int unsigned qsz);
        return (i + 1) * qsz - 1;
    endfunction

endpackage

// File: rtl/sd_rr_arb.sv
// Round-robin arbiter with a combinational one-hot grant and a registered
// priority pointer. After a grant to index g the pointer moves to g+1 (mod nq)
// so g gets the lowest priority next cycle; with no grant the pointer holds.
//   clk   : clock
//   reset : asynchronous active-low reset (pointer -> 0)
//   req   : request vector
//   grant : one-hot grant, all-zero when req is zero
module sd_rr_arb
    import sd_mq_pkg::*;
#(
    parameter int unsigned nq = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [nq-1:0] req,
    output logic [nq-1:0] grant
);

    localparam int unsigned pw = $clog2(nq);

    logic [pw-1:0]     ptr;
    logic [pw-1:0]     ptr_next;
    logic [MAX_NQ-1:0] grant_full;
    logic [IDX_W-1:0]  grant_idx;
    logic              unused_grant_bits;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        grant_full = rr_select(MAX_NQ'(req), IDX_W'(ptr), nq);
        grant_idx  = onehot_to_idx(grant_full);
        ptr_next   = (grant_idx == IDX_W'(nq - 1)) ? '0 : pw'(grant_idx + 1'b1);
    end

    assign grant             = grant_full[nq-1:0];
    assign unused_grant_bits = ^grant_full;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/sd_mq_mem_arb.sv
// Shares one two-port memory (1-cycle read latency) between nq FIFO head
// controllers (write port) and nq tail controllers (read port).
//   clk, reset          : clock, asynchronous active-low reset
//   h_req/h_enable      : head requests / one-hot round-robin grant
//   h_we/h_addr/h_data  : head write strobe, pointers and data (slice i per head)
//   t_req/t_enable      : tail requests / one-hot round-robin grant
//   t_re/t_addr         : tail read strobe and pointers
//   t_rd_vld/t_rd_data  : per-tail read-return valid, broadcast read data
//   bound_low/high      : static per-queue partition [i*qsz, (i+1)*qsz-1]
//   mem_*               : memory write/read port
//   proto_err           : sticky flag for a strobe raised without its enable
module sd_mq_mem_arb
    import sd_mq_pkg::*;
#(
    parameter int unsigned nq    = 4,
    parameter int unsigned width = 8,
    parameter int unsigned depth = 1024,
    parameter int unsigned asz   = $clog2(depth),
    parameter int unsigned qsz   = depth / nq
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [nq-1:0]       h_req,
    output logic [nq-1:0]       h_enable,
    input  logic [nq-1:0]       h_we,
    input  logic [nq*asz-1:0]   h_addr,
    input  logic [nq*width-1:0] h_data,
    input  logic [nq-1:0]       t_req,
    output logic [nq-1:0]       t_enable,
    input  logic [nq-1:0]       t_re,
    input  logic [nq*asz-1:0]   t_addr,
    output logic [nq-1:0]       t_rd_vld,
    output logic [width-1:0]    t_rd_data,
    output logic [nq*asz-1:0]   bound_low,
    output logic [nq*asz-1:0]   bound_high,
    output logic                mem_wr_en,
    output logic [asz-1:0]      mem_wr_addr,
    output logic [width-1:0]    mem_wr_data,
    output logic                mem_rd_en,
    output logic [asz-1:0]      mem_rd_addr,
    input  logic [width-1:0]    mem_rd_data,
    output logic                proto_err
);

    sd_rr_arb #(.nq(nq)) u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (h_req),
        .grant (h_enable)
    );

    sd_rr_arb #(.nq(nq)) u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   (t_req),
        .grant (t_enable)
    );

    // Strobes are gated by their grant, so an out-of-turn access has no
    // memory effect; it only raises proto_err.
    assign mem_wr_en = |(h_we & h_enable);
    assign mem_rd_en = |(t_re & t_enable);

    always_comb begin
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_addr = '0;
        for (int unsigned i = 0; i < nq; i++) begin
            if (h_enable[i]) begin
                mem_wr_addr = h_addr[i*asz +: asz];
                mem_wr_data = h_data[i*width +: width];
            end
            if (t_enable[i]) begin
                mem_rd_addr = t_addr[i*asz +: asz];
            end
        end
    end

    // Read data is shared; t_rd_vld tells each tail whether it is theirs.
    assign t_rd_data = mem_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_rd_vld  <= '0;
            proto_err <= 1'b0;
        end else begin
            t_rd_vld <= t_re & t_enable;
            if (|(h_we & ~h_enable) || |(t_re & ~t_enable)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // depth is a multiple of nq, so (i+1)*qsz-1 never exceeds depth-1.
    for (genvar i = 0; i < nq; i++) begin : g_bounds
        assign bound_low[i*asz +: asz]  = asz'(bound_low_of(i, qsz));
        assign bound_high[i*asz +: asz] = asz'(bound_high_of(i, qsz));
    end

endmodule

// File: tb/tb_sd_mq_mem_arb.sv
// Directed bench for sd_mq_mem_arb (nq=4, width=8, depth=1024).
// Stimulus pushes expected memory writes and read returns into scoreboards;
// a monitor on the falling edge pops and compares whenever the DUT strobes
// mem_wr_en or t_rd_vld. Grants and same-cycle muxing are checked inline.
module tb_sd_mq_mem_arb;

    localparam int NQ = 4;
    localparam int W  = 8;
    localparam int D  = 1024;
    localparam int AS = 10;

    typedef struct {
        logic [AS-1:0] addr;
        logic [W-1:0]  data;
    } wr_exp_t;

    typedef struct {
        logic [NQ-1:0] vld;
        logic [W-1:0]  data;
    } rd_exp_t;

    logic             clk;
    logic             reset;
    logic [NQ-1:0]    h_req, h_enable, h_we;
    logic [NQ*AS-1:0] h_addr;
    logic [NQ*W-1:0]  h_data;
    logic [NQ-1:0]    t_req, t_enable, t_re, t_rd_vld;
    logic [NQ*AS-1:0] t_addr;
    logic [W-1:0]     t_rd_data;
    logic [NQ*AS-1:0] bound_low, bound_high;
    logic             mem_wr_en, mem_rd_en, proto_err;
    logic [AS-1:0]    mem_wr_addr, mem_rd_addr;
    logic [W-1:0]     mem_wr_data, mem_rd_data;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t wr_got;
    rd_exp_t rd_got;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mem [D];

    sd_mq_mem_arb #(.nq(NQ), .width(W), .depth(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .h_req       (h_req),
        .h_enable    (h_enable),
        .h_we        (h_we),
        .h_addr      (h_addr),
        .h_data      (h_data),
        .t_req       (t_req),
        .t_enable    (t_enable),
        .t_re        (t_re),
        .t_addr      (t_addr),
        .t_rd_vld    (t_rd_vld),
        .t_rd_data   (t_rd_data),
        .bound_low   (bound_low),
        .bound_high  (bound_high),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural two-port memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        h_req = '0; h_we = '0; h_addr = '0; h_data = '0;
        t_req = '0; t_re = '0; t_addr = '0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wr_got = wr_q.pop_front();
                check("sb_wr_addr", 32'(mem_wr_addr), 32'(wr_got.addr));
                check("sb_wr_data", 32'(mem_wr_data), 32'(wr_got.data));
            end
        end
        if (t_rd_vld != '0) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                rd_got = rd_q.pop_front();
                check("sb_rd_vld", 32'(t_rd_vld), 32'(rd_got.vld));
                check("sb_rd_data", 32'(t_rd_data), 32'(rd_got.data));
            end
        end
    end

    int          exp_low  [NQ] = '{0, 256, 512, 768};
    int          exp_high [NQ] = '{255, 511, 767, 1023};
    logic [3:0]  rr_exp   [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Reset state and static bounds.
        repeat (2) @(negedge clk);
        check("rst_h_enable", 32'(h_enable), 32'd0);
        check("rst_t_enable", 32'(t_enable), 32'd0);
        check("rst_t_rd_vld", 32'(t_rd_vld), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("bound_low%0d", i), 32'(bound_low[i*AS +: AS]), 32'(exp_low[i]));
            check($sformatf("bound_high%0d", i), 32'(bound_high[i*AS +: AS]), 32'(exp_high[i]));
        end

        // Round-robin with all heads requesting.
        next_cycle();
        reset = 1'b1;
        h_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            check($sformatf("rr_grant%0d", i), 32'(h_enable), 32'(rr_exp[i]));
            check("rr_no_wr", 32'(mem_wr_en), 32'd0);
        end

        // Move wr_ptr to 1, then skip idle requesters.
        next_cycle();
        h_req = 4'b0001;
        @(negedge clk);
        check("skip_pre", 32'(h_enable), 32'b0001);
        next_cycle();
        h_req = 4'b1001;
        @(negedge clk);
        check("skip_a", 32'(h_enable), 32'b1000);
        next_cycle();
        @(negedge clk);
        check("skip_b", 32'(h_enable), 32'b0001);

        // Write mux: head 2 writes 0xA5 to 600 (wr_ptr is 1 here).
        next_cycle();
        h_req = 4'b0100;
        h_we  = 4'b0100;
        h_addr[0*AS +: AS] = 10'd11;  h_data[0*W +: W] = 8'h11;
        h_addr[1*AS +: AS] = 10'd22;  h_data[1*W +: W] = 8'h22;
        h_addr[2*AS +: AS] = 10'd600; h_data[2*W +: W] = 8'hA5;
        h_addr[3*AS +: AS] = 10'd33;  h_data[3*W +: W] = 8'h33;
        wr_q.push_back('{addr: 10'd600, data: 8'hA5});
        @(negedge clk);
        check("wm_grant", 32'(h_enable), 32'b0100);
        check("wm_en", 32'(mem_wr_en), 32'd1);
        check("wm_addr", 32'(mem_wr_addr), 32'd600);
        check("wm_data", 32'(mem_wr_data), 32'hA5);

        // Seed address 900 via head 3.
        next_cycle();
        h_req = 4'b1000;
        h_we  = 4'b1000;
        h_addr[3*AS +: AS] = 10'd900; h_data[3*W +: W] = 8'h77;
        wr_q.push_back('{addr: 10'd900, data: 8'h77});
        @(negedge clk);
        check("seed_grant", 32'(h_enable), 32'b1000);

        // Tail 3 reads 900 while head 3 writes 901.
        next_cycle();
        h_addr[3*AS +: AS] = 10'd901; h_data[3*W +: W] = 8'h99;
        wr_q.push_back('{addr: 10'd901, data: 8'h99});
        t_req = 4'b1000;
        t_re  = 4'b1000;
        t_addr[0*AS +: AS] = 10'd1;
        t_addr[1*AS +: AS] = 10'd2;
        t_addr[2*AS +: AS] = 10'd3;
        t_addr[3*AS +: AS] = 10'd900;
        rd_q.push_back('{vld: 4'b1000, data: 8'h77});
        @(negedge clk);
        check("rd_grant", 32'(t_enable), 32'b1000);
        check("rd_en", 32'(mem_rd_en), 32'd1);
        check("rd_addr", 32'(mem_rd_addr), 32'd900);
        check("rd_cc_wr_addr", 32'(mem_wr_addr), 32'd901);
        check("rd_vld_not_yet", 32'(t_rd_vld), 32'd0);

        // Tail 1 reads 600; head 1 requests without writing (wr_ptr -> 2).
        next_cycle();
        h_req = 4'b0010;
        h_we  = 4'b0000;
        t_req = 4'b0010;
        t_re  = 4'b0010;
        t_addr[1*AS +: AS] = 10'd600;
        rd_q.push_back('{vld: 4'b0010, data: 8'hA5});
        @(negedge clk);
        check("rd_vld_n1", 32'(t_rd_vld), 32'b1000);
        check("rd_data_n1", 32'(t_rd_data), 32'h77);
        check("rd2_addr", 32'(mem_rd_addr), 32'd600);
        check("rd2_no_wr", 32'(mem_wr_en), 32'd0);

        // Protocol error: h_we[1] without a grant.
        next_cycle();
        idle_inputs();
        h_we = 4'b0010;
        @(negedge clk);
        check("pe_no_grant", 32'(h_enable), 32'd0);
        check("pe_masked", 32'(mem_wr_en), 32'd0);
        next_cycle();
        h_we = 4'b0000;
        @(negedge clk);
        check("pe_set", 32'(proto_err), 32'd1);
        next_cycle();
        @(negedge clk);
        check("pe_sticky", 32'(proto_err), 32'd1);

        // Read launched just before reset: no valid may come back.
        next_cycle();
        t_req = 4'b0001;
        t_re  = 4'b0001;
        t_addr[0*AS +: AS] = 10'd600;
        @(negedge clk);
        check("mid_rd_en", 32'(mem_rd_en), 32'd1);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_no_vld", 32'(t_rd_vld), 32'd0);
        check("mid_pe_clr", 32'(proto_err), 32'd0);

        // Pointers restart at 0 (rd_ptr was 2, wr_ptr was 2).
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        h_req = 4'b1111;
        t_req = 4'b1111;
        @(negedge clk);
        check("post_rst_h", 32'(h_enable), 32'b0001);
        check("post_rst_t", 32'(t_enable), 32'b0001);

        next_cycle();
        idle_inputs();
        repeat (4) @(negedge clk);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
